// File: rtl/regread_arbiter.sv
// Round-robin arbiter that shares one register-file read mux between
// NREQ requesters. Each read takes an IDLE (arbitrate) cycle and a READ
// (mux settle) cycle. The mux output is captured into rdata, and a one-hot
// rvalid pulses for the requester that was served.
module regread_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*SEL_W-1:0]   req_addr,
    output logic [NREQ-1:0]         gnt,
    output logic [SEL_W-1:0]        mux_sel,
    input  logic [DATA_W-1:0]       mux_q,
    output logic [DATA_W-1:0]       rdata,
    output logic [NREQ-1:0]         rvalid,
    output logic                    busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [NREQ-1:0]     gnt_r;
    logic [NREQ-1:0]     gnt_nxt_s;
    logic [NREQ-1:0]     rvalid_r;
    logic [NREQ-1:0]     rvalid_nxt_s;
    logic [SEL_W-1:0]    mux_sel_r;
    logic [SEL_W-1:0]    mux_sel_nxt_s;
    logic [DATA_W-1:0]   rdata_r;
    logic [DATA_W-1:0]   rdata_nxt_s;
    logic [IDX_W-1:0]    last_grant_r;
    logic [IDX_W-1:0]    last_grant_nxt_s;
    logic                busy_r;
    logic [NREQ-1:0]     eligible_s;
    logic                found_s;
    logic [IDX_W-1:0]    winner_s;

    // Round-robin search: first eligible index after the last winner.
    // A requester whose rvalid is still high has not yet had a chance
    // to drop req, so it is masked out to avoid serving it twice.
    always_comb begin
        eligible_s = req & ~rvalid_r;
        found_s    = 1'b0;
        winner_s   = {IDX_W{1'b0}};
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last_grant_r) + k) % NREQ;
            if (!found_s && eligible_s[idx]) begin
                found_s  = 1'b1;
                winner_s = IDX_W'(idx);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Next-state and next-output logic for the IDLE/READ sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        gnt_nxt_s        = gnt_r;
        rvalid_nxt_s     = {NREQ{1'b0}};
        mux_sel_nxt_s    = mux_sel_r;
        rdata_nxt_s      = rdata_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s) begin
                    gnt_nxt_s           = {NREQ{1'b0}};
                    gnt_nxt_s[winner_s] = 1'b1;
                    mux_sel_nxt_s       = req_addr[winner_s*SEL_W +: SEL_W];
                    last_grant_nxt_s    = winner_s;
                    state_nxt_s         = ST_READ;
                end else begin
                    gnt_nxt_s   = {NREQ{1'b0}};
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                rdata_nxt_s  = mux_q;
                rvalid_nxt_s = gnt_r;
                gnt_nxt_s    = {NREQ{1'b0}};
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                gnt_nxt_s   = {NREQ{1'b0}};
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            gnt_r        <= {NREQ{1'b0}};
            rvalid_r     <= {NREQ{1'b0}};
            mux_sel_r    <= {SEL_W{1'b0}};
            rdata_r      <= {DATA_W{1'b0}};
            last_grant_r <= IDX_W'(NREQ - 1);
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            gnt_r        <= gnt_nxt_s;
            rvalid_r     <= rvalid_nxt_s;
            mux_sel_r    <= mux_sel_nxt_s;
            rdata_r      <= rdata_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            busy_r       <= (state_nxt_s == ST_READ);
        end
    end

    assign gnt     = gnt_r;
    assign rvalid  = rvalid_r;
    assign mux_sel = mux_sel_r;
    assign rdata   = rdata_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_regread_arbiter.sv
// Directed bench for regread_arbiter: a register bank whose register k
// reads as k*16'h1111, driven through reset, single, simultaneous,
// fairness, address-latching and reset-during-READ scenarios.
module tb_regread_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_addr;
    logic [3:0]  gnt;
    logic [3:0]  mux_sel;
    logic [15:0] mux_q;
    logic [15:0] rdata;
    logic [3:0]  rvalid;
    logic        busy;

    int check_count;
    int error_count;

    regread_arbiter #(.NREQ(4), .DATA_W(16), .SEL_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .mux_sel  (mux_sel),
        .mux_q    (mux_q),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .busy     (busy)
    );

    // Register bank model: register k holds k*16'h1111.
    assign mux_q = {4{mux_sel}};

    // Free-running clock, active edge is the rising edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_gnt;
        check_count = 0;
        error_count = 0;
        reset    = 1'b0;
        req      = 4'($urandom);
        req_addr = 16'($urandom);

        // Reset takes effect with no clock edge.
        #1 reset = 1'b1;
        #1;
        check_value("rst_gnt",     32'(gnt),     32'h0);
        check_value("rst_rvalid",  32'(rvalid),  32'h0);
        check_value("rst_busy",    32'(busy),    32'h0);
        check_value("rst_mux_sel", 32'(mux_sel), 32'h0);
        check_value("rst_rdata",   32'(rdata),   32'h0);
        req      = 4'b0000;
        req_addr = 16'h0000;
        step();
        step();
        reset = 1'b0;

        // Single request from requester 1 at address 5.
        req      = 4'b0010;
        req_addr = 16'h0050;
        step();
        check_value("single_gnt",     32'(gnt),     32'h2);
        check_value("single_mux_sel", 32'(mux_sel), 32'h5);
        check_value("single_busy",    32'(busy),    32'h1);
        step();
        check_value("single_rvalid",  32'(rvalid),  32'h2);
        check_value("single_rdata",   32'(rdata),   32'h5555);
        check_value("single_idle",    32'(busy),    32'h0);
        // Requester keeps req high across the rvalid edge: must not be re-served.
        @(posedge clk);
        #1 req = 4'b0000;
        step();
        check_value("single_no_regrant", 32'(gnt),    32'h0);
        check_value("single_rv_clear",   32'(rvalid), 32'h0);

        // Simultaneous requests straight after reset.
        do_reset();
        req      = 4'b1111;
        req_addr = 16'h4321;
        for (int i = 0; i < 4; i++) begin
            step();
            check_value("all_gnt", 32'(gnt), 32'(4'b0001 << i));
            check_value("all_sel", 32'(mux_sel), 32'(i + 1));
            step();
            check_value("all_rvalid", 32'(rvalid), 32'(4'b0001 << i));
            check_value("all_rdata", 32'(rdata), 32'((i + 1) * 16'h1111));
            req[i] = 1'b0;
        end

        // Fairness: requesters 0 and 2 never drop req.
        req      = 4'b0101;
        req_addr = 16'h0706;
        for (int i = 0; i < 4; i++) begin
            exp_gnt = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            step();
            check_value("fair_gnt", 32'(gnt), 32'(exp_gnt));
            step();
            check_value("fair_rvalid", 32'(rvalid), 32'(exp_gnt));
            check_value("fair_rdata", 32'(rdata), (i % 2 == 0) ? 32'h6666 : 32'h7777);
        end
        req = 4'b0000;
        step();
        check_value("fair_idle_gnt",  32'(gnt),  32'h0);
        check_value("fair_idle_busy", 32'(busy), 32'h0);

        // Address latched at grant; change during READ is ignored.
        req      = 4'b1000;
        req_addr = 16'h3000;
        step();
        check_value("addr_gnt", 32'(gnt), 32'h8);
        req_addr = 16'h9000;
        step();
        check_value("addr_rdata", 32'(rdata), 32'h3333);
        req = 4'b0000;
        step();
        req      = 4'b1000;
        req_addr = 16'hF000;
        step();
        check_value("addr15_sel", 32'(mux_sel), 32'hF);
        step();
        check_value("addr15_rdata", 32'(rdata), 32'hFFFF);
        req = 4'b0000;
        step();
        step();
        check_value("sel_hold", 32'(mux_sel), 32'hF);

        // Reset during READ aborts the read and restarts priority at 0.
        req      = 4'b0001;
        req_addr = 16'h0012;
        step();
        check_value("rr_gnt0", 32'(gnt), 32'h1);
        reset = 1'b1;
        #1;
        check_value("rr_gnt_clr",  32'(gnt),    32'h0);
        check_value("rr_busy_clr", 32'(busy),   32'h0);
        check_value("rr_rv_clr",   32'(rvalid), 32'h0);
        step();
        check_value("rr_no_rvalid", 32'(rvalid), 32'h0);
        check_value("rr_rdata",     32'(rdata),  32'h0);
        req   = 4'b0011;
        reset = 1'b0;
        step();
        check_value("rr_first_gnt", 32'(gnt), 32'h1);
        step();
        check_value("rr_rvalid", 32'(rvalid), 32'h1);
        check_value("rr_rdata2", 32'(rdata),  32'h2222);
        req = 4'b0000;
        step();
        step();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
